// File: rtl/serdes_pkg.sv
// Shared constants and types for the soft DDR serializer/deserializer pair.
// TMDS control symbols double as alignment commas on the receive side.
package serdes_pkg;

  localparam int SER_RATIO = 5;
  localparam int WORD_W    = 10;
  localparam int HIST_W    = 20;

  typedef logic [3:0] slip_t;

  typedef enum logic {
    IDLE,
    HOLD
  } slip_state_e;

  typedef enum logic {
    SEARCH,
    LOCKED
  } align_state_e;

  localparam logic [WORD_W-1:0] TMDS_CTL0 = 10'h354;
  localparam logic [WORD_W-1:0] TMDS_CTL1 = 10'h0AB;
  localparam logic [WORD_W-1:0] TMDS_CTL2 = 10'h154;
  localparam logic [WORD_W-1:0] TMDS_CTL3 = 10'h2AB;

  function automatic slip_t slip_inc(input slip_t s);
    return (s == slip_t'(WORD_W - 1)) ? '0 : s + slip_t'(1);
  endfunction

endpackage

// File: rtl/iserdes_word_sel.sv
// Registered 10-of-20 barrel selector: picks the word window at the
// current bit offset on each capture and holds it until the next one.
module iserdes_word_sel
  import serdes_pkg::*;
(
  input  logic              clk_ser,
  input  logic              rst,
  input  logic [HIST_W-1:0] hist,
  input  slip_t             slip,
  input  logic              cap,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid
);

  logic [WORD_W-1:0] sel;
  logic [WORD_W-1:0] dout_d, dout_q;
  logic              vld_d, vld_q;

  // Window select, offsets outside 0..9 never occur and fall back to 0
  always_comb begin
    sel = hist[WORD_W-1:0];
    for (int i = 0; i < WORD_W; i++) begin
      if (slip == slip_t'(i)) sel = hist[i +: WORD_W];
    end
    dout_d = cap ? sel : dout_q;
    vld_d  = cap;
  end

  // Output word and strobe registers
  always_ff @(posedge clk_ser or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;

endmodule

// File: rtl/iserdes_shift.sv
// Soft 1:10 DDR deserializer with bitslip alignment, LSB first.
// Optional comma auto-alignment when ISERDES_COMMA_ALIGN_EN is defined.
module iserdes_shift
  import serdes_pkg::*;
#(
  parameter int                BITSLIP_HOLDOFF = 2,
  parameter logic [WORD_W-1:0] COMMA           = 10'h354
) (
  input  logic              clk_ser,
  input  logic              rst,
  input  logic              din_rise,
  input  logic              din_fall,
  input  logic              bitslip,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  output slip_t             slip,
  output logic              locked
);

  localparam int HC_W =
    (BITSLIP_HOLDOFF < 1) ? 1 : $clog2(BITSLIP_HOLDOFF + 1);

  logic [HIST_W-1:0] hist_d, hist_q;
  logic [2:0]        ph_d, ph_q;
  logic              primed_d, primed_q;
  logic              word_stb;
  logic              cap;

  slip_state_e       st_d, st_q;
  logic [HC_W-1:0]   hold_cnt_d, hold_cnt_q;
  slip_t             slip_d, slip_q;
  slip_t             slip_ext;
  logic              accept;

  // Sample history shift, word phase and first-word priming
  always_comb begin
    hist_d   = {din_fall, din_rise, hist_q[HIST_W-1:2]};
    word_stb = (ph_q == 3'(SER_RATIO - 1));
    ph_d     = word_stb ? 3'd0 : ph_q + 3'd1;
    primed_d = primed_q | word_stb;
    cap      = word_stb & primed_q;
  end

  // Slip FSM state register
  always_ff @(posedge clk_ser or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  // Slip FSM next state: holdoff ends at a strobe once the count is spent
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (bitslip) st_d = HOLD;
      HOLD:    if (word_stb && hold_cnt_q == '0) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Slip FSM outputs: accepted request, holdoff count, bitslip offset
  always_comb begin
    accept     = (st_q == IDLE) & bitslip;
    hold_cnt_d = hold_cnt_q;
    if (accept) begin
      hold_cnt_d = HC_W'(BITSLIP_HOLDOFF);
    end else if (st_q == HOLD && word_stb && hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HC_W'(1);
    end
    slip_ext = accept ? slip_inc(slip_q) : slip_q;
  end

`ifdef ISERDES_COMMA_ALIGN_EN
  align_state_e al_d, al_q;
  logic         hit;
  slip_t        hit_o;
  logic         locked_d, locked_q;

  // Comma search over all ten offsets, lowest offset wins
  always_comb begin
    hit   = 1'b0;
    hit_o = '0;
    for (int o = WORD_W - 1; o >= 0; o--) begin
      if (hist_q[o +: WORD_W] == COMMA) begin
        hit   = 1'b1;
        hit_o = slip_t'(o);
      end
    end
  end

  // Align FSM state register
  always_ff @(posedge clk_ser or posedge rst) begin
    if (rst) al_q <= SEARCH;
    else     al_q <= al_d;
  end

  // Align FSM next state: manual slip drops lock and restarts search
  always_comb begin
    al_d = al_q;
    unique case (al_q)
      SEARCH:  if (cap && hit) al_d = LOCKED;
      LOCKED:  if (accept) al_d = SEARCH;
      default: al_d = SEARCH;
    endcase
  end

  // Align FSM outputs: comma offset overrides a same-edge bitslip
  always_comb begin
    slip_d   = slip_ext;
    locked_d = (al_d == LOCKED);
    if (al_q == SEARCH && cap && hit) slip_d = hit_o;
  end

  // Lock flag register
  always_ff @(posedge clk_ser or posedge rst) begin
    if (rst) locked_q <= 1'b0;
    else     locked_q <= locked_d;
  end

  assign locked = locked_q;
`else
  logic unused_comma;

  // Offset comes from bitslip only
  always_comb begin
    slip_d = slip_ext;
  end

  assign unused_comma = ^COMMA;
  assign locked       = 1'b0;
`endif

  // Datapath and slip registers
  always_ff @(posedge clk_ser or posedge rst) begin
    if (rst) begin
      hist_q     <= '0;
      ph_q       <= '0;
      primed_q   <= 1'b0;
      hold_cnt_q <= '0;
      slip_q     <= '0;
    end else begin
      hist_q     <= hist_d;
      ph_q       <= ph_d;
      primed_q   <= primed_d;
      hold_cnt_q <= hold_cnt_d;
      slip_q     <= slip_d;
    end
  end

  iserdes_word_sel u_word_sel (
    .clk_ser    (clk_ser),
    .rst        (rst),
    .hist       (hist_q),
    .slip       (slip_q),
    .cap        (cap),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  assign slip = slip_q;

endmodule

// File: tb/tb_iserdes_shift.sv
// Directed bench for iserdes_shift with a word scoreboard.
// Expected words come from the raw sample stream, not a shift register.
`timescale 1ns/1ps
module tb_iserdes_shift;
  import serdes_pkg::*;

  localparam int          HOLDOFF = 2;
  localparam logic [9:0]  COMMA_W = 10'h354;

  logic       clk_ser = 1'b0;
  logic       rst = 1'b1;
  logic       din_rise = 1'b0;
  logic       din_fall = 1'b0;
  logic       bitslip = 1'b0;
  logic [9:0] dout;
  logic       dout_valid;
  logic [3:0] slip;
  logic       locked;

  iserdes_shift #(
    .BITSLIP_HOLDOFF (HOLDOFF),
    .COMMA           (COMMA_W)
  ) dut (
    .clk_ser    (clk_ser),
    .rst        (rst),
    .din_rise   (din_rise),
    .din_fall   (din_fall),
    .bitslip    (bitslip),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slip       (slip),
    .locked     (locked)
  );

  always #5 clk_ser = ~clk_ser;

  int         checks = 0;
  int         errors = 0;
  int         e;
  logic       sbuf [0:4095];
  logic [9:0] pat_w;
  int         pat_q;
  logic [9:0] sb_q [$];
  logic [9:0] last_dout;
  logic [3:0] m_slip;
  int         m_hold;
  bit         m_hold_st;
  bit         m_locked;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word seen at capture edge en with offset o: stream bit 2*en-22+o+k
  function automatic logic [9:0] win(input int en, input int o);
    logic [9:0] w;
    int idx;
    for (int k = 0; k < 10; k++) begin
      idx  = 2 * en - 22 + o + k;
      w[k] = (idx < 0) ? 1'b0 : sbuf[idx];
    end
    return w;
  endfunction

  task automatic step(input logic bs);
    int    idx;
    bit    cap;
    bit    acc;
    int    hit_o;
    logic [9:0] w;
    idx      = 2 * e;
    din_rise = pat_w[(idx + pat_q) % 10];
    din_fall = pat_w[(idx + 1 + pat_q) % 10];
    sbuf[idx]     = din_rise;
    sbuf[idx + 1] = din_fall;
    bitslip  = bs;
    @(posedge clk_ser);
    e++;
    cap = ((e - 1) % 5 == 4) && (e >= 10);
    if (cap) sb_q.push_back(win(e, m_slip));
    acc   = !m_hold_st && bs;
    hit_o = -1;
`ifdef ISERDES_COMMA_ALIGN_EN
    if (cap && !m_locked) begin
      for (int o = 9; o >= 0; o--) begin
        if (win(e, o) == COMMA_W) hit_o = o;
      end
    end
`endif
    if (acc) m_slip = (m_slip == 4'd9) ? 4'd0 : m_slip + 4'd1;
    if (acc) begin
      m_hold_st = 1'b1;
      m_hold    = HOLDOFF;
    end else if (m_hold_st && ((e - 1) % 5 == 4)) begin
      if (m_hold == 0) m_hold_st = 1'b0;
      else             m_hold--;
    end
    if (hit_o >= 0) begin
      m_slip   = 4'(hit_o);
      m_locked = 1'b1;
    end else if (m_locked && acc) begin
      m_locked = 1'b0;
    end
    #1;
    chk("dout_valid", dout_valid, cap);
    if (dout_valid === 1'b1) begin
      chk("sb_has_entry", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        w = sb_q.pop_front();
        chk("dout", dout, w);
      end
      last_dout = dout;
    end
    chk("slip", slip, m_slip);
    chk("locked", locked, m_locked);
  endtask

  task automatic do_reset(input logic bs_during);
    rst     = 1'b1;
    bitslip = bs_during;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_slip", slip, 0);
    chk("rst_locked", locked, 0);
    repeat (2) @(posedge clk_ser);
    #1;
    chk("rst_slip_held", slip, 0);
    bitslip = 1'b0;
    #2;
    rst = 1'b0;
    e = 0;
    m_slip = '0;
    m_hold = 0;
    m_hold_st = 1'b0;
    m_locked = 1'b0;
    last_dout = '0;
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int pulses;
    bit aligned;
    bit first_chg;
    bit saw_wrap;
    int last_chg;
    logic [3:0] prev;

    // Constant rise=1 fall=0
    pat_w = 10'h155;
    pat_q = 0;
    do_reset(1'b0);
    nv = 0;
    repeat (9) begin
      step(1'b0);
      if (dout_valid) nv++;
    end
    chk("no_valid_first9", nv, 0);
    step(1'b0);
    chk("first_strobe_e10", dout_valid, 1);
    repeat (5) step(1'b0);
    chk("strobe_e15", dout_valid, 1);
    chk("steady_155", dout, 10'h155);
    step(1'b1);
    repeat (4) step(1'b0);
    chk("strobe_e20", dout_valid, 1);
    chk("after_slip_2aa", dout, 10'h2AA);
    chk("after_slip_val", slip, 1);

    // Loopback stream of 0x3A5, needs offset 5
    pat_w = 10'h3A5;
    pat_q = 7;
    do_reset(1'b0);
    pulses = 0;
    aligned = 1'b0;
    repeat (15) step(1'b0);
    for (int p = 0; p < 10 && !aligned; p++) begin
      if (last_dout === 10'h3A5) begin
        aligned = 1'b1;
      end else begin
        step(1'b1);
        pulses++;
        repeat (15) step(1'b0);
      end
    end
    chk("loop_aligned", aligned, 1);
    chk("loop_pulses_le9", pulses <= 9, 1);
    repeat (20) begin
      step(1'b0);
      if (dout_valid) chk("loop_word", dout, 10'h3A5);
    end

    // Bitslip held high: one slip per 3 word periods, wrap 9->0
    pat_w = 10'h155;
    pat_q = 0;
    do_reset(1'b0);
    first_chg = 1'b1;
    saw_wrap = 1'b0;
    last_chg = 0;
    prev = 4'd0;
    repeat (160) begin
      step(1'b1);
      if (slip !== prev) begin
        if (!first_chg) chk("slip_period", e - last_chg, (HOLDOFF + 1) * 5);
        if (prev == 4'd9) begin
          chk("wrap_to_0", slip, 0);
          saw_wrap = 1'b1;
        end
        first_chg = 1'b0;
        last_chg = e;
        prev = slip;
      end
    end
    chk("wrap_seen", saw_wrap, 1);
    step(1'b0);

    // Reset mid-word at ph==2
    do_reset(1'b0);
    step(1'b1);
    repeat (19) step(1'b0);
    while (e % 5 != 2) step(1'b0);
    chk("pre_rst_slip", slip, 1);
    chk("pre_rst_dout", dout, 10'h2AA);
    #2;
    do_reset(1'b1);
    nv = 0;
    repeat (9) begin
      step(1'b0);
      if (dout_valid) nv++;
    end
    chk("post_rst_no_valid9", nv, 0);
    chk("post_rst_slip", slip, 0);
    step(1'b0);
    chk("post_rst_valid_e10", dout_valid, 1);

`ifdef ISERDES_COMMA_ALIGN_EN
    // Comma stream at offset 7
    pat_w = COMMA_W;
    pat_q = 5;
    do_reset(1'b0);
    repeat (15) step(1'b0);
    chk("comma_locked", locked, 1);
    chk("comma_slip7", slip, 7);
    chk("comma_dout", dout, COMMA_W);
    step(1'b1);
    chk("comma_unlock", locked, 0);
    chk("comma_slip8", slip, 8);
    repeat (5) step(1'b0);
    chk("comma_relock", locked, 1);
    chk("comma_reslip7", slip, 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
